// File: rtl/johnson_pkg.sv
// -----------------------------------------------------------------------------
// johnson_pkg
// Shared definitions for Johnson-code producers and consumers:
//   - decoder FSM state constants (UNLOCKED / ACQUIRE / LOCKED)
//   - jc_legal : code has at most one adjacent-bit transition
//   - jc_index : code -> state index (0 .. 2n-1)
//   - jc_next  : successor code (right shift, inverted LSB into MSB)
// The functions work on a JC_MAXW-bit container plus the active width n so
// that one definition serves every instance width up to JC_MAXW.
// -----------------------------------------------------------------------------
package johnson_pkg;

  localparam int JC_MAXW = 64;  // widest supported Johnson code
  localparam int JC_IDXW = 8;   // container width for counts and indices

  typedef logic [1:0] jc_state_t;

  localparam jc_state_t UNLOCKED = 2'd0;
  localparam jc_state_t ACQUIRE  = 2'd1;
  localparam jc_state_t LOCKED   = 2'd2;

  // A Johnson code is one run of 1s and one run of 0s, so at most one
  // adjacent pair of bits may differ. All-0 and all-1 have zero transitions.
  function automatic logic jc_legal(input logic [JC_MAXW-1:0] code, input int n);
    logic [JC_IDXW-1:0] trans;
    trans = '0;
    for (int i = 0; i < JC_MAXW - 1; i++) begin
      if (i < n - 1) begin
        trans = trans + {{(JC_IDXW-1){1'b0}}, code[i+1] ^ code[i]};
      end else begin
        trans = trans;
      end
    end
    return (trans <= 8'd1);
  endfunction

  // Filling phase (MSB set) has index = number of 1s; draining phase counts
  // down from 2n. The pc == 0 branch replaces the "mod 2n" so no divider is
  // needed.
  function automatic logic [JC_IDXW-1:0] jc_index(input logic [JC_MAXW-1:0] code,
                                                  input int n);
    logic [JC_IDXW-1:0] pc;
    logic [JC_IDXW-1:0] two_n;
    logic [JC_IDXW-1:0] idx;
    pc    = '0;
    two_n = JC_IDXW'(2 * n);
    for (int i = 0; i < JC_MAXW; i++) begin
      if (i < n) begin
        pc = pc + {{(JC_IDXW-1){1'b0}}, code[i]};
      end else begin
        pc = pc;
      end
    end
    if (code[n-1]) begin
      idx = pc;
    end else if (pc == '0) begin
      idx = '0;
    end else begin
      idx = two_n - pc;
    end
    return idx;
  endfunction

  // Next code in the sequence: shift right, feed ~LSB into bit n-1.
  function automatic logic [JC_MAXW-1:0] jc_next(input logic [JC_MAXW-1:0] code,
                                                 input int n);
    logic [JC_MAXW-1:0] nxt;
    nxt = '0;
    for (int i = 0; i < JC_MAXW - 1; i++) begin
      if (i < n - 1) begin
        nxt[i] = code[i+1];
      end else begin
        nxt[i] = 1'b0;
      end
    end
    nxt[n-1] = ~code[0];
    return nxt;
  endfunction

endpackage

// File: rtl/johnson_decode_comb.sv
// -----------------------------------------------------------------------------
// johnson_decode_comb
// Purely combinational Johnson-code classifier.
// Ports:
//   i_code  [N-1:0]  Johnson code sample
//   o_legal          code is one of the 2N legal codes
//   o_index [IW-1:0] decoded state index (meaningful only when o_legal)
// -----------------------------------------------------------------------------
module johnson_decode_comb
  import johnson_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]  i_code,
  output logic          o_legal,
  output logic [IW-1:0] o_index
);

  logic [JC_MAXW-1:0] w_code_ext;
  logic [JC_IDXW-1:0] w_idx_full;
  logic               w_idx_fits;
  logic               w_legal_raw;

  // Zero-extend the sample into the package function container.
  always_comb begin
    w_code_ext         = '0;
    w_code_ext[N-1:0]  = i_code;
  end

  // Classify and decode the sample.
  always_comb begin
    w_legal_raw = jc_legal(w_code_ext, N);
    w_idx_full  = jc_index(w_code_ext, N);
    // A legal code always decodes below 2N; any high bit set would mean a
    // corrupted decode, so it is treated as illegal rather than truncated.
    w_idx_fits  = ((w_idx_full >> IW) == '0);
    o_legal     = w_legal_raw & w_idx_fits;
    o_index     = w_idx_full[IW-1:0];
  end

endmodule

// File: rtl/johnson_decoder.sv
// -----------------------------------------------------------------------------
// johnson_decoder
// Decodes a sampled Johnson-coded bus to a binary index and monitors the
// sequence: legality, correct succession, lock tracking and a saturating
// error count. All outputs are registered (one cycle after a valid sample).
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   code_in      [N-1:0] Johnson code sample
//   code_valid   code_in is sampled this cycle
//   clr_err      synchronous clear of err_count (wins over an increment)
//   index        [IW-1:0] last legal decoded index
//   index_valid  one-cycle pulse per sample
//   illegal      last sample was not a legal code
//   seq_err      last sample was legal but not the expected successor while locked
//   locked       sequence lock achieved
//   err_count    [ERR_W-1:0] saturating count of illegal and seq_err events
// -----------------------------------------------------------------------------
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8,
  localparam int IW      = $clog2(2 * N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     code_in,
  input  logic             code_valid,
  input  logic             clr_err,
  output logic [IW-1:0]    index,
  output logic             index_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int GW = 4;  // holds LOCK_CNT up to 15

  // Registered state and outputs
  jc_state_t        r_state;
  logic [IW-1:0]    r_index;
  logic [GW-1:0]    r_good_cnt;
  logic             r_index_valid;
  logic             r_illegal;
  logic             r_seq_err;
  logic             r_locked;
  logic [ERR_W-1:0] r_err_count;

  // Decode results and next-state values
  logic             w_legal;
  logic [IW-1:0]    w_dec_index;
  logic [IW-1:0]    w_exp;
  logic             w_match;
  logic [GW-1:0]    w_good_inc;
  jc_state_t        w_state_nxt;
  logic [IW-1:0]    w_index_nxt;
  logic [GW-1:0]    w_good_nxt;
  logic             w_valid_nxt;
  logic             w_illegal_nxt;
  logic             w_seq_err_nxt;
  logic             w_locked_nxt;
  logic [ERR_W-1:0] w_err_nxt;

  johnson_decode_comb #(
    .N (N)
  ) u_decode (
    .i_code  (code_in),
    .o_legal (w_legal),
    .o_index (w_dec_index)
  );

  // Expected successor of the last legal index, wrapping 2N-1 back to 0.
  always_comb begin
    if (r_index == IW'(2 * N - 1)) begin
      w_exp = '0;
    end else begin
      w_exp = r_index + {{(IW-1){1'b0}}, 1'b1};
    end
    w_match    = (w_dec_index == w_exp);
    w_good_inc = r_good_cnt + {{(GW-1){1'b0}}, 1'b1};
  end

  // Lock FSM and per-sample flag generation.
  always_comb begin
    w_state_nxt   = r_state;
    w_index_nxt   = r_index;
    w_good_nxt    = r_good_cnt;
    w_locked_nxt  = r_locked;
    w_valid_nxt   = 1'b0;
    w_illegal_nxt = 1'b0;
    w_seq_err_nxt = 1'b0;
    if (code_valid) begin
      w_valid_nxt = 1'b1;
      if (!w_legal) begin
        // Any illegal code drops tracking; the index keeps the last legal value.
        w_illegal_nxt = 1'b1;
        w_state_nxt   = UNLOCKED;
        w_good_nxt    = '0;
        w_locked_nxt  = 1'b0;
      end else begin
        w_index_nxt = w_dec_index;
        case (r_state)
          UNLOCKED: begin
            w_good_nxt   = '0;
            w_state_nxt  = ACQUIRE;
            w_locked_nxt = 1'b0;
          end
          ACQUIRE: begin
            if (w_match) begin
              w_good_nxt = w_good_inc;
              if (w_good_inc >= GW'(LOCK_CNT)) begin
                w_state_nxt  = LOCKED;
                w_locked_nxt = 1'b1;
              end else begin
                w_state_nxt  = ACQUIRE;
              end
            end else begin
              // New reference point; no error is flagged while acquiring.
              w_good_nxt  = '0;
              w_state_nxt = ACQUIRE;
            end
          end
          LOCKED: begin
            if (w_match) begin
              w_state_nxt = LOCKED;
            end else begin
              // Includes a repeated code from a stalled source.
              w_seq_err_nxt = 1'b1;
              w_good_nxt    = '0;
              w_state_nxt   = ACQUIRE;
              w_locked_nxt  = 1'b0;
            end
          end
          default: begin
            w_good_nxt   = '0;
            w_state_nxt  = UNLOCKED;
            w_locked_nxt = 1'b0;
          end
        endcase
      end
    end else begin
      w_valid_nxt = 1'b0;
    end
  end

  // Saturating error counter; clear wins over a same-cycle increment.
  always_comb begin
    if (clr_err) begin
      w_err_nxt = '0;
    end else if ((w_illegal_nxt || w_seq_err_nxt) && (r_err_count != {ERR_W{1'b1}})) begin
      w_err_nxt = r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      w_err_nxt = r_err_count;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= UNLOCKED;
      r_index       <= '0;
      r_good_cnt    <= '0;
      r_index_valid <= 1'b0;
      r_illegal     <= 1'b0;
      r_seq_err     <= 1'b0;
      r_locked      <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_index       <= w_index_nxt;
      r_good_cnt    <= w_good_nxt;
      r_index_valid <= w_valid_nxt;
      r_illegal     <= w_illegal_nxt;
      r_seq_err     <= w_seq_err_nxt;
      r_locked      <= w_locked_nxt;
      r_err_count   <= w_err_nxt;
    end
  end

  assign index       = r_index;
  assign index_valid = r_index_valid;
  assign illegal     = r_illegal;
  assign seq_err     = r_seq_err;
  assign locked      = r_locked;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_johnson_decoder.sv
// -----------------------------------------------------------------------------
// tb_johnson_decoder
// Reference model: legal codes are found by looking the sample up in a table
// of the 2N codes generated by repeated jc_next from all-zeros; lock is
// "at least LOCK_CNT correct successions in a row since the last break".
// -----------------------------------------------------------------------------
module tb_johnson_decoder;
  import johnson_pkg::*;

  localparam int N        = 4;
  localparam int LOCK_CNT = 3;
  localparam int ERR_W    = 8;
  localparam int IW       = 3;
  localparam int NS       = 2 * N;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     code_in;
  logic             code_valid;
  logic             clr_err;
  logic [IW-1:0]    index;
  logic             index_valid;
  logic             illegal;
  logic             seq_err;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  always #5 clk = ~clk;

  johnson_decoder #(
    .N        (N),
    .LOCK_CNT (LOCK_CNT),
    .ERR_W    (ERR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .clr_err     (clr_err),
    .index       (index),
    .index_valid (index_valid),
    .illegal     (illegal),
    .seq_err     (seq_err),
    .locked      (locked),
    .err_count   (err_count)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [N-1:0] m_tab [NS];

  // Model state
  int m_index, m_err, m_run;
  bit m_track, m_valid, m_illegal, m_seq, m_locked;
  bit cmp_en = 1'b0;

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int lookup(logic [N-1:0] c);
    for (int k = 0; k < NS; k++) begin
      if (m_tab[k] == c) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_index = 0; m_err = 0; m_run = 0;
    m_track = 0; m_valid = 0; m_illegal = 0; m_seq = 0; m_locked = 0;
  endtask

  task automatic model_step(logic [N-1:0] c, logic v, logic clr);
    int k;
    m_valid   = v;
    m_illegal = 0;
    m_seq     = 0;
    if (v) begin
      k = lookup(c);
      if (k < 0) begin
        m_illegal = 1;
        m_track   = 0;
        m_run     = 0;
      end else begin
        if (m_track && k == (m_index + 1) % NS) begin
          if (m_run < 1000) m_run++;
        end else begin
          m_seq = m_locked;
          m_run = 0;
        end
        m_track = 1;
        m_index = k;
      end
      m_locked = (m_run >= LOCK_CNT);
    end
    if (clr) m_err = 0;
    else if ((m_illegal || m_seq) && m_err < ERR_MAX) m_err++;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(logic [N-1:0] c, logic v, logic clr);
    code_in    = c;
    code_valid = v;
    clr_err    = clr;
    @(posedge clk);
    model_step(c, v, clr);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_index"},       index,       0);
    chk({tag, "_index_valid"}, index_valid, 0);
    chk({tag, "_illegal"},     illegal,     0);
    chk({tag, "_seq_err"},     seq_err,     0);
    chk({tag, "_locked"},      locked,      0);
    chk({tag, "_err_count"},   err_count,   0);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("index",       index,       m_index);
      chk("index_valid", index_valid, m_valid);
      chk("illegal",     illegal,     m_illegal);
      chk("seq_err",     seq_err,     m_seq);
      chk("locked",      locked,      m_locked);
      chk("err_count",   err_count,   m_err);
    end
  end

  initial begin
    logic [JC_MAXW-1:0] t;
    logic [N-1:0]       c;
    logic               v, clr;
    int                 cur, r;

    // Build the code table from the successor rule.
    t = '0;
    for (int k = 0; k < NS; k++) begin
      m_tab[k] = t[N-1:0];
      t = jc_next(t, N);
    end
    chk("tab_pin3", m_tab[3], 4'b1110);
    chk("tab_pin6", m_tab[6], 4'b0011);
    chk("lookup_1010", lookup(4'b1010), -1);
    chk("lookup_0001", lookup(4'b0001), 7);

    // Reset
    rst = 1'b1; code_in = '0; code_valid = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    cmp_en = 1'b1;

    // 1: free-running sequence from 0000, including wrap 7 -> 0
    for (int i = 0; i <= NS; i++) begin
      step(m_tab[i % NS], 1'b1, 1'b0);
      if (i == 2) chk("t1_locked_s2", locked, 0);
      if (i == 3) chk("t1_locked_s3", locked, 1);
    end
    chk("t1_wrap_index", index, 0);
    chk("t1_wrap_locked", locked, 1);
    chk("t1_err", err_count, 0);

    // 2: illegal injection then relock
    step(4'b1010, 1'b1, 1'b0);
    chk("t2_illegal", illegal, 1);
    chk("t2_locked", locked, 0);
    chk("t2_err", err_count, 1);
    chk("t2_index_hold", index, 0);
    step(4'b1100, 1'b1, 1'b0);
    step(4'b1110, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    chk("t2_not_yet", locked, 0);
    step(4'b0111, 1'b1, 1'b0);
    chk("t2_relock", locked, 1);
    chk("t2_index5", index, 5);

    // 3: locked at 3, then jump to 0011
    for (int i = 6; i <= 11; i++) step(m_tab[i % NS], 1'b1, 1'b0);
    chk("t3_at3", index, 3);
    step(4'b0011, 1'b1, 1'b0);
    chk("t3_seq_err", seq_err, 1);
    chk("t3_index", index, 6);
    chk("t3_locked", locked, 0);
    chk("t3_err", err_count, 2);

    // 4: relock, then repeat 1100
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    chk("t4_locked", locked, 1);
    step(4'b1100, 1'b1, 1'b0);
    chk("t4_first_ok", seq_err, 0);
    step(4'b1100, 1'b1, 1'b0);
    chk("t4_repeat_seq_err", seq_err, 1);
    chk("t4_repeat_locked", locked, 0);
    chk("t4_err", err_count, 3);

    // 5: saturate err_count, then clear against an illegal pulse
    for (int i = 0; i < ERR_MAX - 3; i++) step((i % 2) ? 4'b0101 : 4'b1010, 1'b1, 1'b0);
    chk("t5_reach_max", err_count, ERR_MAX);
    for (int i = 0; i < 6; i++) step((i % 2) ? 4'b0101 : 4'b1010, 1'b1, 1'b0);
    chk("t5_saturated", err_count, ERR_MAX);
    step(4'b1010, 1'b1, 1'b1);
    chk("t5_clr_err", err_count, 0);
    chk("t5_clr_illegal", illegal, 1);

    // 6: asynchronous reset mid-cycle while locked
    for (int i = 0; i < 4; i++) step(m_tab[i], 1'b1, 1'b0);
    chk("t6_locked_before", locked, 1);
    code_valid = 1'b0;
    @(posedge clk);
    model_step(code_in, 1'b0, 1'b0);
    #3 rst = 1'b1;
    model_reset();
    #1;
    chk_all_zero("t6_async");
    @(negedge clk);
    rst = 1'b0;
    step(4'b0111, 1'b1, 1'b0);
    chk("t6_first_index", index, 5);
    chk("t6_first_seq_err", seq_err, 0);
    chk("t6_first_locked", locked, 0);
    step(4'b0011, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("t6_relock", locked, 1);

    // Randomized phase: mostly correct successions with stalls, jumps,
    // arbitrary codes, idle cycles and occasional clears.
    cur = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      c = m_tab[(cur + 1) % NS];
      else if (r == 6) c = m_tab[cur];
      else if (r == 7) c = m_tab[$urandom_range(0, NS - 1)];
      else             c = 4'($urandom_range(0, 15));
      v   = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 63) == 0);
      step(c, v, clr);
      if (v && lookup(c) >= 0) cur = lookup(c);
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
